// File: rtl/e_muldiv_unit_if.sv
// E-stage mul/div port bundle: op/operands and D-stage use in, HI/LO/busy/stall out.
interface e_muldiv_unit_if;
  logic [2:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        D_md_stall;

  modport master (
    output E_md_op, E_A, E_B, D_md_use,
    input  HI, LO, busy, D_md_stall
  );

  modport slave (
    input  E_md_op, E_A, E_B, D_md_use,
    output HI, LO, busy, D_md_stall
  );
endinterface

// File: rtl/e_muldiv_unit.sv
// HI/LO owner: result computed at start, held in hi_p/lo_p, committed after a
// fixed busy countdown so the pipeline sees a multi-cycle unit.
module e_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  e_muldiv_unit_if.slave md
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy;
  logic        is_start;

  assign busy     = (cnt_q != 4'd0);
  assign is_start = (md.E_md_op >= OP_MULT) && (md.E_md_op <= OP_DIVU);

  // Multiply: sign- or zero-extend to 64 bits, low 64 of the product is exact.
  logic        m_sgn;
  logic [63:0] a_ext, b_ext, prod;
  assign m_sgn = (md.E_md_op == OP_MULT);
  assign a_ext = {{32{m_sgn & md.E_A[31]}}, md.E_A};
  assign b_ext = {{32{m_sgn & md.E_B[31]}}, md.E_B};
  assign prod  = a_ext * b_ext;

  // Signed divide via magnitudes keeps MIN_INT / -1 well defined (wraps to MIN_INT).
  logic        d_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign d_sgn = (md.E_md_op == OP_DIV);
  assign a_neg = d_sgn & md.E_A[31];
  assign b_neg = d_sgn & md.E_B[31];
  assign a_mag = a_neg ? -md.E_A : md.E_A;
  assign b_mag = b_neg ? -md.E_B : md.E_B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_p_d = hi_p_q;
    lo_p_d = lo_p_q;
    cnt_d  = cnt_q;
    if (busy) begin
      if (cnt_q == 4'd1) begin
        cnt_d = 4'd0;
        hi_d  = hi_p_q;
        lo_d  = lo_p_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      unique case (md.E_md_op)
        OP_MULT, OP_MULTU: begin
          cnt_d  = 4'(MULT_CYCLES);
          hi_p_d = prod[63:32];
          lo_p_d = prod[31:0];
        end
        OP_DIV, OP_DIVU: begin
          cnt_d = 4'(DIV_CYCLES);
          // Divide by zero still occupies the unit but leaves HI/LO as they are.
          if (md.E_B == 32'd0) begin
            hi_p_d = hi_q;
            lo_p_d = lo_q;
          end else begin
            hi_p_d = rem;
            lo_p_d = quot;
          end
        end
        OP_MTHI: hi_d = md.E_A;
        OP_MTLO: lo_d = md.E_A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_p_q <= 32'd0;
      lo_p_q <= 32'd0;
      cnt_q  <= 4'd0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_p_q <= hi_p_d;
      lo_p_q <= lo_p_d;
      cnt_q  <= cnt_d;
    end
  end

  assign md.HI         = hi_q;
  assign md.LO         = lo_q;
  assign md.busy       = busy;
  assign md.D_md_stall = md.D_md_use & (busy | is_start);
endmodule

// File: tb/tb_e_muldiv_unit.sv
// Bench for e_muldiv_unit: directed test-plan cases, then random ops against a
// cycle-indexed model (busy window + pending values from plain 64-bit arithmetic).
module tb_e_muldiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_muldiv_unit_if u_if ();
  e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (u_if.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model: cycle index, last busy cycle of the running op, pending result.
  int          cyc = 0;
  int          bz_end = -1;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  function automatic bit m_busy();
    return cyc <= bz_end;
  endfunction

  task automatic m_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd1: begin sq = sa * sb; p_hi = sq[63:32]; p_lo = sq[31:0]; end
      3'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
      3'd3: if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
            else begin sq = sa / sb; sr = sa % sb; p_hi = sr[31:0]; p_lo = sq[31:0]; end
      default: if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
               else begin p_hi = a % b; p_lo = a / b; end
    endcase
    bz_end = cyc + ((op <= 3'd2) ? MC : DC);
  endtask

  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic use_d, input logic rst);
    @(negedge clk);
    u_if.E_md_op  = op;
    u_if.E_A      = a;
    u_if.E_B      = b;
    u_if.D_md_use = use_d;
    reset         = rst;
    #1;
    chk("busy",  {63'd0, u_if.busy}, {63'd0, m_busy()});
    chk("hi",    {32'd0, u_if.HI}, {32'd0, m_hi});
    chk("lo",    {32'd0, u_if.LO}, {32'd0, m_lo});
    chk("stall", {63'd0, u_if.D_md_stall},
         {63'd0, use_d & (m_busy() | (op >= 3'd1 && op <= 3'd4))});
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; bz_end = -1;
    end else if (m_busy()) begin
      if (cyc == bz_end) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (op >= 3'd1 && op <= 3'd4) begin
      m_start(op, a, b);
    end else if (op == 3'd5) begin
      m_hi = a;
    end else if (op == 3'd6) begin
      m_lo = a;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) step(3'd0, $urandom, $urandom, use_d, 1'b0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    u_if.E_md_op = 3'd0; u_if.E_A = 0; u_if.E_B = 0; u_if.D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;

    // Reset state
    step(3'd0, 0, 0, 1'b0, 1'b1);
    #1;
    chk("rst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("rst_hi", {32'd0, u_if.HI}, 64'd0);

    step(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #1;
    chk("mult_hi", {32'd0, u_if.HI}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, u_if.LO}, 64'hFFFF_FFFE);

    step(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #1;
    chk("multu_hi", {32'd0, u_if.HI}, 64'h1);
    chk("multu_lo", {32'd0, u_if.LO}, 64'hFFFF_FFFE);

    step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    chk("div_lo", {32'd0, u_if.LO}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, u_if.HI}, 64'hFFFF_FFFF);

    step(3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    chk("divu_lo", {32'd0, u_if.LO}, 64'd14);
    chk("divu_hi", {32'd0, u_if.HI}, 64'd2);

    step(3'd4, 32'd100, 32'd0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    chk("div0_lo", {32'd0, u_if.LO}, 64'd14);
    chk("div0_hi", {32'd0, u_if.HI}, 64'd2);

    // Stall window across a mult, then mthi once free
    step(3'd1, 32'd3, 32'd5, 1'b1, 1'b0);
    idle(MC, 1'b1);
    #1;
    chk("stall_fall", {63'd0, u_if.D_md_stall}, 64'd0);
    step(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    #1;
    chk("mthi", {32'd0, u_if.HI}, 64'h1234_5678);

    // Reset in 4th busy cycle drops the pending divide
    step(3'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(3'd0, 0, 0, 1'b0, 1'b1);
    #1;
    chk("rstmid_busy", {63'd0, u_if.busy}, 64'd0);
    chk("rstmid_lo", {32'd0, u_if.LO}, 64'd0);
    idle(DC + 2, 1'b0);
    #1;
    chk("rstmid_nocommit", {u_if.HI, u_if.LO}, 64'd0);

    // Ops while busy are ignored
    step(3'd4, 32'd50, 32'd6, 1'b0, 1'b0);
    step(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    step(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    step(3'd1, 32'd7, 32'd7, 1'b0, 1'b0);
    idle(DC - 3, 1'b0);
    #1;
    chk("ign_lo", {32'd0, u_if.LO}, 64'd8);
    chk("ign_hi", {32'd0, u_if.HI}, 64'd2);
    chk("ign_busy", {63'd0, u_if.busy}, 64'd0);

    for (int i = 0; i < 3000; i++)
      step(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 200) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
